// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with valid/ready handshakes and flush.
// Define MULDIV_RESULT_REUSE_EN to reuse the last completed result for repeated operands.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 2,
    parameter int TAG_W    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int W2    = 2 * XLEN;
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_BITS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    // Low half for MUL/DIV/DIVU, high half for MULH*/REM/REMU.
    function automatic logic [XLEN-1:0] pick(input logic [2:0] op, input logic [W2-1:0] v);
        if (op[2]) pick = op[1] ? v[W2-1:XLEN] : v[XLEN-1:0];
        else       pick = (op[1:0] == 2'd0) ? v[XLEN-1:0] : v[W2-1:XLEN];
    endfunction

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              neg_q, neg_d, aneg_q, aneg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W2-1:0]     acc_q, acc_d, mcand_q, mcand_d;
    logic [XLEN-1:0]   opb_q, opb_d, res_q, res_d;

    logic              a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, accept;
    logic [XLEN-1:0]   a_mag, b_mag, quo, rem;
    logic [W2-1:0]     add, fin;
    logic [XLEN:0]     sh, diff;

`ifdef MULDIV_RESULT_REUSE_EN
    logic              hit_vld_q, hit_vld_d, hit;
    logic [XLEN-1:0]   hit_a_q, hit_a_d, hit_b_q, hit_b_d;
    logic [2:0]        hit_cls_q, hit_cls_d;
    logic [W2-1:0]     hit_val_q, hit_val_d;
`endif

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = res_q;
    assign tag_o    = tag_q;

    always_comb begin
        a_sgn  = (op_i == 3'd0) || (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
        b_sgn  = (op_i == 3'd0) || (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
        a_neg  = a_sgn & a_i[XLEN-1];
        b_neg  = b_sgn & b_i[XLEN-1];
        a_mag  = a_neg ? -a_i : a_i;
        b_mag  = b_neg ? -b_i : b_i;
        b_zero = (b_i == '0);
        ovf    = op_i[2] & ~op_i[0] & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);
        accept = valid_i & ready_o & ~flush_i;

        add = '0;
        for (int i = 0; i < MUL_BITS; i++)
            if (opb_q[i]) add = add + (mcand_q << i);

        sh   = acc_q[W2-1:XLEN-1];
        diff = sh - {1'b0, opb_q};
        quo  = '0;
        rem  = '0;
        fin  = '0;

        state_d = state_q;
        op_d    = op_q;
        tag_d   = tag_q;
        neg_d   = neg_q;
        aneg_d  = aneg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        opb_d   = opb_q;
        res_d   = res_q;
`ifdef MULDIV_RESULT_REUSE_EN
        hit_vld_d = hit_vld_q;
        hit_a_d   = hit_a_q;
        hit_b_d   = hit_b_q;
        hit_cls_d = hit_cls_q;
        hit_val_d = hit_val_q;
        hit = hit_vld_q && (a_i == hit_a_q) && (b_i == hit_b_q) &&
              ({op_i[2], a_sgn, b_sgn} == hit_cls_q);
`endif

        unique case (state_q)
            S_IDLE: if (accept) begin
                op_d   = op_i;
                tag_d  = tag_i;
                neg_d  = a_neg ^ b_neg;
                aneg_d = a_neg;
                cnt_d  = '0;
                opb_d  = b_mag;
                if (op_i[2] && b_zero) begin
                    res_d   = op_i[1] ? a_i : '1;
                    state_d = S_DONE;
                end else if (ovf) begin
                    res_d   = op_i[1] ? '0 : a_i;
                    state_d = S_DONE;
`ifdef MULDIV_RESULT_REUSE_EN
                end else if (hit) begin
                    res_d   = pick(op_i, hit_val_q);
                    state_d = S_DONE;
`endif
                end else begin
`ifdef MULDIV_RESULT_REUSE_EN
                    hit_vld_d = 1'b0;
                    hit_a_d   = a_i;
                    hit_b_d   = b_i;
                    hit_cls_d = {op_i[2], a_sgn, b_sgn};
`endif
                    if (op_i[2]) begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        state_d = S_DIV;
                    end else begin
                        acc_d   = '0;
                        mcand_d = {{XLEN{1'b0}}, a_mag};
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d   = acc_q + add;
                mcand_d = mcand_q << MUL_BITS;
                opb_d   = opb_q >> MUL_BITS;
                cnt_d   = cnt_q + 1'b1;
                fin     = neg_q ? -acc_d : acc_d;
                if (cnt_q == MUL_LAST) begin
                    res_d   = pick(op_q, fin);
                    state_d = S_DONE;
`ifdef MULDIV_RESULT_REUSE_EN
                    hit_vld_d = 1'b1;
                    hit_val_d = fin;
`endif
                end
            end
            S_DIV: begin
                // Restoring step: shift {rem,quo} left, keep the trial difference if non-negative.
                if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                else             acc_d = {sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                quo   = neg_q  ? -acc_d[XLEN-1:0]  : acc_d[XLEN-1:0];
                rem   = aneg_q ? -acc_d[W2-1:XLEN] : acc_d[W2-1:XLEN];
                fin   = {rem, quo};
                if (cnt_q == DIV_LAST) begin
                    res_d   = pick(op_q, fin);
                    state_d = S_DONE;
`ifdef MULDIV_RESULT_REUSE_EN
                    hit_vld_d = 1'b1;
                    hit_val_d = fin;
`endif
                end
            end
            S_DONE: if (ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d = S_IDLE;
`ifdef MULDIV_RESULT_REUSE_EN
            hit_vld_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            tag_q   <= '0;
            neg_q   <= 1'b0;
            aneg_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            opb_q   <= '0;
            res_q   <= '0;
`ifdef MULDIV_RESULT_REUSE_EN
            hit_vld_q <= 1'b0;
            hit_a_q   <= '0;
            hit_b_q   <= '0;
            hit_cls_q <= '0;
            hit_val_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            neg_q   <= neg_d;
            aneg_q  <= aneg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
`ifdef MULDIV_RESULT_REUSE_EN
            hit_vld_q <= hit_vld_d;
            hit_a_q   <= hit_a_d;
            hit_b_q   <= hit_b_d;
            hit_cls_q <= hit_cls_d;
            hit_val_q <= hit_val_d;
`endif
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32, MUL_BITS=2); latencies counted from the accept edge.
module tb_muldiv_unit;
    logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
    logic        ready_o, valid_o;
    logic [2:0]  op_i = '0;
    logic [31:0] a_i = '0, b_i = '0, result_o;
    logic [3:0]  tag_i = '0, tag_o;
    int vecs = 0, errs = 0;

`ifdef MULDIV_RESULT_REUSE_EN
    localparam int DIV_REUSE_LAT = 1;
    localparam int MUL_REUSE_LAT = 1;
`else
    localparam int DIV_REUSE_LAT = 33;
    localparam int MUL_REUSE_LAT = 17;
`endif

    muldiv_unit #(.XLEN(32), .MUL_BITS(2), .TAG_W(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .tag_o(tag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg);
        op_i = op; a_i = a; b_i = b; tag_i = tg; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tg, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        issue(op, a, b, tg);
        wait_valid(lat);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " result"}, result_o, exp_r);
        chk({nm, " tag"}, {28'd0, tag_o}, {28'd0, tg});
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        chk({nm, " idle after pop"}, {30'd0, ready_o, valid_o}, 32'b10);
    endtask

    initial begin
        int lat;
        bit saw;
        #12;
        chk("reset ctl", {30'd0, ready_o, valid_o}, 32'b10);
        chk("reset result", result_o, 32'h0);
        chk("reset tag", {28'd0, tag_o}, 32'h0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        run_op("mulh min*min",   3'd1, 32'h8000_0000, 32'h8000_0000, 4'h1, 32'h4000_0000, 17);
        run_op("mul min*min",    3'd0, 32'h8000_0000, 32'h8000_0000, 4'h2, 32'h0000_0000, MUL_REUSE_LAT);
        run_op("mulhsu -1*max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 32'hFFFF_FFFF, 17);
        run_op("mulhu max*max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h4, 32'hFFFF_FFFE, 17);
        run_op("mul -3*5",       3'd0, 32'hFFFF_FFFD, 32'd5,         4'h5, 32'hFFFF_FFF1, 17);
        run_op("mulhu min*2",    3'd3, 32'h8000_0000, 32'd2,         4'h6, 32'h0000_0001, 17);
        run_op("div -7/2",       3'd4, 32'hFFFF_FFF9, 32'd2,         4'h7, 32'hFFFF_FFFD, 33);
        run_op("rem -7/2",       3'd6, 32'hFFFF_FFF9, 32'd2,         4'h8, 32'hFFFF_FFFF, DIV_REUSE_LAT);
        run_op("div 7/-2",       3'd4, 32'd7,         32'hFFFF_FFFE, 4'h9, 32'hFFFF_FFFD, 33);
        run_op("rem -7/-2",      3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 4'hA, 32'hFFFF_FFFF, 33);
        run_op("divu max/3",     3'd5, 32'hFFFF_FFFF, 32'd3,         4'hB, 32'h5555_5555, 33);
        run_op("remu 7/0",       3'd7, 32'd7,         32'd0,         4'hC, 32'd7,         1);
        run_op("div ovf",        3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'hD, 32'h8000_0000, 1);
        run_op("rem ovf",        3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'hE, 32'h0000_0000, 1);
        run_op("divu 5/0",       3'd5, 32'd5,         32'd0,         4'hF, 32'hFFFF_FFFF, 1);
        run_op("div -5/0",       3'd4, 32'hFFFF_FFFB, 32'd0,         4'h1, 32'hFFFF_FFFF, 1);

        // Back-pressure: result must hold while the consumer stalls.
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h9);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            chk("hold result", result_o, 32'hFFFF_FFFE);
            chk("hold tag", {28'd0, tag_o}, 32'h9);
            chk("hold ctl", {30'd0, ready_o, valid_o}, 32'b01);
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1 ready_i = 1'b0;

        // Flush during a divide: no result may ever appear.
        issue(3'd4, 32'd100, 32'd7, 4'h3);
        repeat (4) @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i); #1 flush_i = 1'b0;
        chk("flush ctl", {30'd0, ready_o, valid_o}, 32'b10);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (valid_o) saw = 1'b1;
        end
        chk("flush no valid", {31'd0, saw}, 32'd0);

        // Flush beats a simultaneous request in IDLE.
        valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; a_i = 32'd9; b_i = 32'd0;
        @(posedge clk_i); #1 valid_i = 1'b0; flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 chk("flush blocks accept", {30'd0, ready_o, valid_o}, 32'b10);

        run_op("div 100/7",      3'd4, 32'd100, 32'd7, 4'h4, 32'd14, 33);
        run_op("rem 100/7",      3'd6, 32'd100, 32'd7, 4'h5, 32'd2,  DIV_REUSE_LAT);
        flush_i = 1'b1;
        @(posedge clk_i); #1 flush_i = 1'b0;
        run_op("rem after flush", 3'd6, 32'd100, 32'd7, 4'h6, 32'd2, 33);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
